// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war referee.
package tug_pkg;

  typedef enum logic [1:0] {
    WAIT_REL = 2'd0,
    PLAY     = 2'd1,
    WIN_L    = 2'd2,
    WIN_R    = 2'd3
  } tug_state_e;

  localparam int unsigned NPOS_DEF       = 7;
  localparam int unsigned DB_SAMPLES_DEF = 2;

  function automatic int unsigned centre_idx(input int unsigned npos);
    return (npos - 1) / 2;
  endfunction

endpackage

// File: rtl/tug_pb_debounce.sv
// One pushbutton: 2-flop synchronizer, slowen-gated debounce, rising-edge pulse.
module tug_pb_debounce #(
  parameter int unsigned DB_SAMPLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic slowen_i,
  input  logic pb_i,
  output logic synced_o,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CW = $clog2(DB_SAMPLES + 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  // Count consecutive disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (slowen_i) begin
      if (sync2_q != level_q) begin
        if (cnt_q == CW'(DB_SAMPLES - 1)) begin
          level_d = ~level_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= pb_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign synced_o = sync2_q;
  assign level_o  = level_q;
  assign press_o  = press_q;

endmodule

// File: rtl/tug_referee.sv
// Tug-of-war game core: debounced button events move a one-hot rope until one end is reached.
module tug_referee
  import tug_pkg::*;
#(
  parameter int unsigned NPOS       = NPOS_DEF,
  parameter int unsigned DB_SAMPLES = DB_SAMPLES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            slowen,
  input  logic            pbl,
  input  logic            pbr,
  output logic [NPOS-1:0] leds,
  output logic            winl,
  output logic            winr
);

  localparam int unsigned    CENTRE   = centre_idx(NPOS);
  localparam logic [NPOS-1:0] LEDS_RST = NPOS'(1) << CENTRE;

  logic sync_l, level_l, press_l;
  logic sync_r, level_r, press_r;

  tug_pb_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_l (
    .clk      (clk),
    .rst      (rst),
    .slowen_i (slowen),
    .pb_i     (pbl),
    .synced_o (sync_l),
    .level_o  (level_l),
    .press_o  (press_l)
  );

  tug_pb_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_r (
    .clk      (clk),
    .rst      (rst),
    .slowen_i (slowen),
    .pb_i     (pbr),
    .synced_o (sync_r),
    .level_o  (level_r),
    .press_o  (press_r)
  );

  tug_state_e      state_q;
  logic [NPOS-1:0] leds_q;
  logic            winl_q, winr_q;
  logic [1:0]      settle_q;

  // settle_q lets the synchronizers refill after reset, so a button held
  // through reset keeps the game in WAIT_REL until it is really released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= WAIT_REL;
      leds_q   <= LEDS_RST;
      winl_q   <= 1'b0;
      winr_q   <= 1'b0;
      settle_q <= 2'd0;
    end else begin
      case (state_q)
        WAIT_REL: begin
          leds_q <= LEDS_RST;
          if (settle_q != 2'd2) begin
            settle_q <= settle_q + 2'd1;
          end else if (!level_l && !level_r && !sync_l && !sync_r) begin
            state_q <= PLAY;
          end
        end
        PLAY: begin
          if (press_l && !press_r) begin
            leds_q <= leds_q << 1;
            if (leds_q[NPOS-2]) begin
              state_q <= WIN_L;
              winl_q  <= 1'b1;
            end
          end else if (press_r && !press_l) begin
            leds_q <= leds_q >> 1;
            if (leds_q[1]) begin
              state_q <= WIN_R;
              winr_q  <= 1'b1;
            end
          end
        end
        WIN_L, WIN_R: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= WAIT_REL;
        end
      endcase
    end
  end

  assign leds = leds_q;
  assign winl = winl_q;
  assign winr = winr_q;

endmodule

// File: tb/tb_tug_referee.sv
// Self-checking bench for tug_referee: vector table, directed corner cases, random phases vs. game model.
module tb_tug_referee;

  localparam int NPOS = 7;
  localparam int DB   = 2;
  localparam int CTR  = (NPOS - 1) / 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            slowen;
  logic            pbl, pbr;
  logic [NPOS-1:0] leds;
  logic            winl, winr;

  int tests = 0;
  int fails = 0;

  tug_referee #(.NPOS(NPOS), .DB_SAMPLES(DB)) dut (
    .clk    (clk),
    .rst    (rst),
    .slowen (slowen),
    .pbl    (pbl),
    .pbr    (pbr),
    .leds   (leds),
    .winl   (winl),
    .winr   (winr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            l;
    logic            r;
    int              n;
    logic [NPOS-1:0] e_leds;
    logic            e_wl;
    logic            e_wr;
  } vec_t;

  vec_t vecs[12];

  // Every cycle: rope one-hot, never two winners, end LED lit exactly when that side has won.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      tests++;
      if (!$onehot(leds) || (winl && winr) || (leds[NPOS-1] != winl) || (leds[0] != winr)) begin
        fails++;
        $display("FAIL invariant t=%0t leds=%b winl=%b winr=%b", $time, leds, winl, winr);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  // One slowen sample: three quiet clocks, then a one-clock strobe.
  task automatic sample();
    slowen = 1'b0;
    repeat (3) @(negedge clk);
    slowen = 1'b1;
    @(negedge clk);
    slowen = 1'b0;
  endtask

  task automatic apply(input logic l, input logic r, input int n);
    pbl = l;
    pbr = r;
    repeat (n) sample();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_out(input string name, input logic [NPOS-1:0] el, input logic wl, input logic wr);
    chk({name, ".leds"}, 32'(leds), 32'(el));
    chk({name, ".winl"}, 32'(winl), 32'(wl));
    chk({name, ".winr"}, 32'(winr), 32'(wr));
  endtask

  task automatic do_reset();
    pbl    = 1'b0;
    pbr    = 1'b0;
    slowen = 1'b0;
    rst    = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // Game-level reference: levels follow buttons held >= DB samples; a lone rising level moves the rope.
  int   m_pos;
  logic m_ll, m_lr, m_wl, m_wr;

  task automatic model_reset();
    m_pos = CTR;
    m_ll  = 1'b0;
    m_lr  = 1'b0;
    m_wl  = 1'b0;
    m_wr  = 1'b0;
  endtask

  task automatic model_phase(input logic l, input logic r);
    logic rl, rr;
    rl = l & ~m_ll;
    rr = r & ~m_lr;
    if (!m_wl && !m_wr) begin
      if (rl && !rr) begin
        m_pos = m_pos + 1;
        if (m_pos == NPOS - 1) m_wl = 1'b1;
      end else if (rr && !rl) begin
        m_pos = m_pos - 1;
        if (m_pos == 0) m_wr = 1'b1;
      end
    end
    m_ll = l;
    m_lr = r;
  endtask

  initial begin
    logic [NPOS-1:0] centre;
    logic [NPOS-1:0] one;
    logic [NPOS-1:0] exp_leds;
    logic            nl, nr;

    one    = NPOS'(1);
    centre = one << CTR;

    vecs[0]  = '{1'b0, 1'b0, 2, 7'b0001000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2, 7'b0010000, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8, 7'b0010000, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 2, 7'b0010000, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1, 7'b0010000, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 2, 7'b0010000, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 2, 7'b0100000, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 2, 7'b0100000, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 2, 7'b1000000, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 2, 7'b1000000, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 2, 7'b1000000, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 2, 7'b1000000, 1'b1, 1'b0};

    rst    = 1'b1;
    pbl    = 1'b0;
    pbr    = 1'b0;
    slowen = 1'b0;
    repeat (2) @(negedge clk);
    check_out("reset", centre, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check_out("release", centre, 1'b0, 1'b0);

    // Single press, long hold, bounce rejection, left win and post-win lockout.
    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].l, vecs[i].r, vecs[i].n);
      check_out($sformatf("vec%0d", i), vecs[i].e_leds, vecs[i].e_wl, vecs[i].e_wr);
    end

    // Simultaneous presses cancel, then three right presses win.
    do_reset();
    apply(1'b1, 1'b1, 2);
    check_out("both", centre, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 2);
    for (int i = 1; i <= 3; i++) begin
      apply(1'b0, 1'b1, 2);
      apply(1'b0, 1'b0, 2);
      exp_leds = centre >> i;
      check_out($sformatf("right%0d", i), exp_leds, 1'b0, (i == 3) ? 1'b1 : 1'b0);
    end
    apply(1'b1, 1'b0, 2);
    check_out("winr_lock", 7'b0000001, 1'b0, 1'b1);

    // Mid-game reset with the left button held through it.
    do_reset();
    apply(1'b1, 1'b0, 2);
    apply(1'b0, 1'b0, 2);
    apply(1'b1, 1'b0, 2);
    check_out("mid_pre", 7'b0100000, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1 check_out("mid_rst", centre, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    apply(1'b1, 1'b0, 4);
    check_out("mid_held", centre, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 3);
    check_out("mid_rel", centre, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 2);
    check_out("mid_play", 7'b0010000, 1'b0, 1'b0);

    // Random phases: clean holds of DB..DB+2 samples or single-sample glitches.
    do_reset();
    model_reset();
    for (int p = 0; p < 120; p++) begin
      nl = ($urandom_range(0, 1) != 0);
      nr = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 3) == 0) begin
        pbl = nl;
        pbr = nr;
        sample();
        apply(m_ll, m_lr, 1);
      end else begin
        apply(nl, nr, int'($urandom_range(DB, DB + 2)));
        model_phase(nl, nr);
      end
      exp_leds = one << m_pos;
      check_out($sformatf("rand%0d", p), exp_leds, m_wl, m_wr);
      if ((m_wl || m_wr) && ($urandom_range(0, 2) == 0)) begin
        do_reset();
        model_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
